// File: rtl/bcd_converter_bank_if.sv
// rtl/bcd_converter_bank_if.sv - request, count and BCD result bundle for bcd_converter_bank
interface bcd_converter_bank_if;
    logic        start;
    logic        busy;
    logic        done;
    logic [7:0]  c9_11;
    logic [7:0]  c9_12;
    logic [7:0]  c9_21;
    logic [7:0]  c9_22;
    logic [7:0]  c4_11;
    logic [7:0]  c4_12;
    logic [7:0]  c4_21;
    logic [7:0]  c4_22;
    logic [11:0] c9_11_d;
    logic [11:0] c9_12_d;
    logic [11:0] c9_21_d;
    logic [11:0] c9_22_d;
    logic [11:0] c4_11_d;
    logic [11:0] c4_12_d;
    logic [11:0] c4_21_d;
    logic [11:0] c4_22_d;

    modport master (
        output start, c9_11, c9_12, c9_21, c9_22, c4_11, c4_12, c4_21, c4_22,
        input  busy, done, c9_11_d, c9_12_d, c9_21_d, c9_22_d,
               c4_11_d, c4_12_d, c4_21_d, c4_22_d
    );

    modport slave (
        input  start, c9_11, c9_12, c9_21, c9_22, c4_11, c4_12, c4_21, c4_22,
        output busy, done, c9_11_d, c9_12_d, c9_21_d, c9_22_d,
               c4_11_d, c4_12_d, c4_21_d, c4_22_d
    );
endinterface

// File: rtl/bcd_converter_bank.sv
// rtl/bcd_converter_bank.sv - eight-channel binary-to-BCD bank with one shared shift-add-3 engine (option: BCD_AUTO_REFRESH_EN)
module bcd_converter_bank (
    input  logic                 clk_1000hz,
    input  logic                 resetn,
    bcd_converter_bank_if.slave  bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [2:0]  ch_q, ch_d;
    logic [2:0]  bit_q, bit_d;
    logic [19:0] work_q, work_d;
    logic        done_q, done_d;
    logic [7:0]  snap_q [8];
    logic [7:0]  snap_d [8];
    logic [11:0] res_q  [8];
    logic [11:0] res_d  [8];
    logic [11:0] out_q  [8];
    logic [11:0] out_d  [8];
    logic [7:0]  in_w   [8];
    logic        start_eff;

`ifdef BCD_AUTO_REFRESH_EN
    logic unused_start;
    assign unused_start = bus.start;
    assign start_eff    = 1'b1;
`else
    assign start_eff    = bus.start;
`endif

    assign in_w[0] = bus.c9_11;
    assign in_w[1] = bus.c9_12;
    assign in_w[2] = bus.c9_21;
    assign in_w[3] = bus.c9_22;
    assign in_w[4] = bus.c4_11;
    assign in_w[5] = bus.c4_12;
    assign in_w[6] = bus.c4_21;
    assign in_w[7] = bus.c4_22;

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = done_q;
    assign bus.c9_11_d = out_q[0];
    assign bus.c9_12_d = out_q[1];
    assign bus.c9_21_d = out_q[2];
    assign bus.c9_22_d = out_q[3];
    assign bus.c4_11_d = out_q[4];
    assign bus.c4_12_d = out_q[5];
    assign bus.c4_21_d = out_q[6];
    assign bus.c4_22_d = out_q[7];

    // One double-dabble step: correct every BCD nibble >= 5, then shift the whole register
    function automatic logic [19:0] dabble_step(input logic [19:0] w);
        logic [19:0] t;
        t = w;
        for (int i = 0; i < 3; i++) begin
            if (t[8 + 4*i +: 4] >= 4'd5) begin
                t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
            end
        end
        return {t[18:0], 1'b0};
    endfunction

    // Sequencer: snapshot, convert channel by channel, then publish all results together
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        bit_d   = bit_q;
        work_d  = work_q;
        done_d  = 1'b0;
        snap_d  = snap_q;
        res_d   = res_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (start_eff) begin
                    snap_d  = in_w;
                    ch_d    = 3'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                work_d  = {12'd0, snap_q[ch_q]};
                bit_d   = 3'd0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                work_d = dabble_step(work_q);
                if (bit_q == 3'd7) begin
                    state_d = S_STORE;
                end else begin
                    bit_d = bit_q + 3'd1;
                end
            end
            S_STORE: begin
                res_d[ch_q] = work_q[19:8];
                if (ch_q == 3'd7) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + 3'd1;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                out_d   = res_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset discards any partial frame and blanks the published outputs
    always_ff @(posedge clk_1000hz) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            ch_q    <= 3'd0;
            bit_q   <= 3'd0;
            work_q  <= 20'd0;
            done_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                snap_q[i] <= 8'd0;
                res_q[i]  <= 12'd0;
                out_q[i]  <= 12'd0;
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            bit_q   <= bit_d;
            work_q  <= work_d;
            done_q  <= done_d;
            snap_q  <= snap_d;
            res_q   <= res_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_bcd_converter_bank.sv
// tb/tb_bcd_converter_bank.sv - directed self-checking bench for bcd_converter_bank
module tb_bcd_converter_bank;

    logic clk_1000hz = 1'b0;
    logic resetn     = 1'b0;

    bcd_converter_bank_if bus();

    bcd_converter_bank dut (
        .clk_1000hz (clk_1000hz),
        .resetn     (resetn),
        .bus        (bus)
    );

    always #5 clk_1000hz = ~clk_1000hz;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt;
    int done_at;
    int busy_bad;

    task automatic set_in(input int ch, input logic [7:0] v);
        case (ch)
            0: bus.c9_11 = v;
            1: bus.c9_12 = v;
            2: bus.c9_21 = v;
            3: bus.c9_22 = v;
            4: bus.c4_11 = v;
            5: bus.c4_12 = v;
            6: bus.c4_21 = v;
            default: bus.c4_22 = v;
        endcase
    endtask

    task automatic set_all(input logic [7:0] v);
        for (int i = 0; i < 8; i++) set_in(i, v);
    endtask

    function automatic logic [11:0] get_out(input int ch);
        case (ch)
            0: return bus.c9_11_d;
            1: return bus.c9_12_d;
            2: return bus.c9_21_d;
            3: return bus.c9_22_d;
            4: return bus.c4_11_d;
            5: return bus.c4_12_d;
            6: return bus.c4_21_d;
            default: return bus.c4_22_d;
        endcase
    endfunction

    // Start at edge E, observe E+1..E+82; optional input change, extra starts and reset at given offsets
    task automatic run_conv(input int chg_at, input logic [7:0] chg_val,
                            input int st_a, input int st_b, input int rst_at);
        @(negedge clk_1000hz);
        bus.start = 1'b1;
        @(posedge clk_1000hz);
        #1;
        bus.start = 1'b0;
        busy_bad  = 0;
        done_cnt  = 0;
        done_at   = -1;
        if (bus.busy !== 1'b1) busy_bad++;
        for (int k = 1; k <= 82; k++) begin
            @(posedge clk_1000hz);
            #1;
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (rst_at < 0 && bus.busy !== (k <= 80)) busy_bad++;
            if (k == chg_at) set_all(chg_val);
            bus.start = (k == st_a - 1 || k == st_b - 1);
            if (k == rst_at - 1) resetn = 1'b0;
            if (k == rst_at) resetn = 1'b1;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.start = 1'b0;
        set_all(8'd77);
        repeat (3) @(posedge clk_1000hz);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy); else n_pass++;
        n_checks++;
        if (bus.done !== 1'b0) $display("FAIL reset_done got=%b want=0", bus.done); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (get_out(i) !== 12'h000) $display("FAIL reset_out%0d got=%h want=000", i, get_out(i));
            else n_pass++;
        end
        resetn = 1'b1;
        @(posedge clk_1000hz);
    endtask

    task automatic test_powers();
        logic [11:0] exp_v [8];
        exp_v = '{12'h001, 12'h002, 12'h004, 12'h008, 12'h016, 12'h032, 12'h064, 12'h128};
        for (int i = 0; i < 8; i++) set_in(i, 8'(1 << i));
        run_conv(-1, 8'd0, -1, -1, -1);
        n_checks++;
        if (done_cnt !== 1) $display("FAIL pow_done_count got=%0d want=1", done_cnt); else n_pass++;
        n_checks++;
        if (done_at !== 81) $display("FAIL pow_done_edge got=%0d want=81", done_at); else n_pass++;
        n_checks++;
        if (busy_bad !== 0) $display("FAIL pow_busy_window bad_cycles=%0d want=0", busy_bad); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (get_out(i) !== exp_v[i]) $display("FAIL pow_out%0d got=%h want=%h", i, get_out(i), exp_v[i]);
            else n_pass++;
        end
        set_all(8'd9);
        repeat (5) @(posedge clk_1000hz);
        #1;
        n_checks++;
        if (bus.c4_22_d !== 12'h128) $display("FAIL pow_hold got=%h want=128", bus.c4_22_d); else n_pass++;
    endtask

    task automatic test_patterns();
        set_all(8'd255);
        run_conv(-1, 8'd0, -1, -1, -1);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (get_out(i) !== 12'h255) $display("FAIL max_out%0d got=%h want=255", i, get_out(i));
            else n_pass++;
        end
        set_all(8'd0);
        run_conv(-1, 8'd0, -1, -1, -1);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (get_out(i) !== 12'h000) $display("FAIL zero_out%0d got=%h want=000", i, get_out(i));
            else n_pass++;
        end
        for (int i = 0; i < 8; i++) set_in(i, (i % 2 == 0) ? 8'd99 : 8'd100);
        run_conv(-1, 8'd0, -1, -1, -1);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (get_out(i) !== ((i % 2 == 0) ? 12'h099 : 12'h100))
                $display("FAIL alt_out%0d got=%h want=%s", i, get_out(i), (i % 2 == 0) ? "099" : "100");
            else n_pass++;
        end
    endtask

    task automatic test_input_change();
        set_all(8'd5);
        run_conv(40, 8'd200, -1, -1, -1);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (get_out(i) !== 12'h005) $display("FAIL snap_out%0d got=%h want=005", i, get_out(i));
            else n_pass++;
        end
        run_conv(-1, 8'd0, -1, -1, -1);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (get_out(i) !== 12'h200) $display("FAIL next_out%0d got=%h want=200", i, get_out(i));
            else n_pass++;
        end
    endtask

    task automatic test_start_ignored();
        set_all(8'd123);
        run_conv(-1, 8'd0, 10, 50, -1);
        n_checks++;
        if (done_cnt !== 1) $display("FAIL ign_done_count got=%0d want=1", done_cnt); else n_pass++;
        n_checks++;
        if (done_at !== 81) $display("FAIL ign_done_edge got=%0d want=81", done_at); else n_pass++;
        n_checks++;
        if (busy_bad !== 0) $display("FAIL ign_busy_window bad_cycles=%0d want=0", busy_bad); else n_pass++;
        n_checks++;
        if (bus.c9_21_d !== 12'h123) $display("FAIL ign_out got=%h want=123", bus.c9_21_d); else n_pass++;
    endtask

    task automatic test_mid_reset();
        set_all(8'd45);
        run_conv(-1, 8'd0, -1, -1, 45);
        n_checks++;
        if (done_cnt !== 0) $display("FAIL rst_done_count got=%0d want=0", done_cnt); else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", bus.busy); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (get_out(i) !== 12'h000) $display("FAIL rst_out%0d got=%h want=000", i, get_out(i));
            else n_pass++;
        end
        run_conv(-1, 8'd0, -1, -1, -1);
        n_checks++;
        if (done_at !== 81) $display("FAIL rst_fresh_edge got=%0d want=81", done_at); else n_pass++;
        n_checks++;
        if (bus.c4_11_d !== 12'h045) $display("FAIL rst_fresh_out got=%h want=045", bus.c4_11_d); else n_pass++;
    endtask

    task automatic test_auto_refresh();
        int found;
        int gap;
        resetn = 1'b0;
        bus.start = 1'b0;
        set_all(8'd17);
        repeat (2) @(posedge clk_1000hz);
        #1;
        resetn = 1'b1;
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(posedge clk_1000hz);
            #1;
            if (bus.done === 1'b1) found = 1;
        end
        n_checks++;
        if (found !== 1) $display("FAIL auto_first_done got=none want=pulse"); else n_pass++;
        n_checks++;
        if (bus.c9_12_d !== 12'h017) $display("FAIL auto_out1 got=%h want=017", bus.c9_12_d); else n_pass++;
        set_all(8'd250);
        gap = -1;
        for (int k = 1; k <= 200 && gap < 0; k++) begin
            @(posedge clk_1000hz);
            #1;
            if (bus.done === 1'b1) gap = k;
        end
        n_checks++;
        if (gap !== 82) $display("FAIL auto_period got=%0d want=82", gap); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (get_out(i) !== 12'h250) $display("FAIL auto_out%0d got=%h want=250", i, get_out(i));
            else n_pass++;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        set_all(8'd0);
`ifdef BCD_AUTO_REFRESH_EN
        test_auto_refresh();
`else
        test_reset();
        test_powers();
        test_patterns();
        test_input_change();
        test_start_ignored();
        test_mid_reset();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
